// File: rtl/mem_stream_reader.sv
// Streams a contiguous, wrapping range of words out of a memory read port with one-cycle
// registered latency, buffering up to two words so downstream backpressure never loses data.
module mem_stream_reader #(
    parameter int addresses = 32,
    parameter int width = 8,
    localparam int addressWidth = $clog2(addresses)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic [addressWidth-1:0] startAddress,
    input  logic [addressWidth:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic [addressWidth-1:0] readAddress,
    output logic                    readEnable,
    input  logic [width-1:0]        readData,
    output logic                    outValid,
    output logic [width-1:0]        outData,
    output logic                    outLast,
    input  logic                    outReady,
    output logic                    state_debug
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [addressWidth-1:0] lastAddress = addressWidth'(addresses - 1);

    state_t                  state;
    state_t                  state_next;
    logic [addressWidth-1:0] pointer;
    logic [addressWidth:0]   remaining;
    logic                    in_flight;
    logic [width-1:0]        fifo_head;
    logic [width-1:0]        fifo_tail;
    logic [1:0]              buf_count;
    logic                    done_q;
    logic [1:0]              occupancy;
    logic                    pop;
    logic                    issue;
    logic                    accept;
    logic                    zero_start;
    logic                    finish;

    // Stream handshake: a word transfers in any cycle where outValid and outReady are both 1;
    // while outValid=1 and outReady=0 the word and outLast are held unchanged.
    assign occupancy  = buf_count + {1'b0, in_flight};
    assign pop        = (buf_count != 2'd0) && outReady;
    assign accept     = (state == IDLE) && start && (length != '0);
    assign zero_start = (state == IDLE) && start && (length == '0);
    assign finish     = pop && outLast;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue only while the words already owed (buffered + in flight, minus this cycle's pop)
    // leave room in the two-entry buffer.
    always_comb begin
        busy        = (state == RUN);
        done        = done_q;
        state_debug = state;
        readAddress = pointer;
        issue       = (state == RUN) && (remaining != '0) && ((occupancy - {1'b0, pop}) < 2'd2);
        readEnable  = issue;
        outValid    = (buf_count != 2'd0);
        outData     = fifo_head;
        outLast     = (state == RUN) && (buf_count == 2'd1) && !in_flight && (remaining == '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pointer   <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            fifo_head <= '0;
            fifo_tail <= '0;
            buf_count <= 2'd0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= finish || zero_start;
            in_flight <= issue;
            if (accept) begin
                pointer   <= startAddress;
                remaining <= length;
            end else if (issue) begin
                pointer   <= (pointer == lastAddress) ? '0 : pointer + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case ({in_flight, pop})
                2'b10: begin
                    if (buf_count == 2'd0) fifo_head <= readData;
                    else                   fifo_tail <= readData;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    fifo_head <= fifo_tail;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd2) begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= readData;
                    end else begin
                        fifo_head <= readData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a cycle table for the basic burst on a 32-word memory, then
// scoreboarded command sequences on 32- and 20-word instances covering wrap, stalls and reset.
module tb_mem_stream_reader;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       sel;
    logic [4:0] startAddress;
    logic [5:0] length;
    logic       outReady;

    logic       start_a, busy_a, done_a, re_a, ov_a, ol_a, st_a;
    logic [4:0] ra_a;
    logic [7:0] rd_a, od_a;
    logic       start_b, busy_b, done_b, re_b, ov_b, ol_b, st_b;
    logic [4:0] ra_b;
    logic [7:0] rd_b, od_b;

    logic       m_busy, m_dn, m_re, m_ov, m_ol;
    logic [4:0] m_ra;
    logic [7:0] m_od;

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [20];
    logic [7:0] exp_q[$];
    logic [4:0] addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       start;
        logic [4:0] addr;
        logic [5:0] len;
        logic       rdy;
        logic       e_busy;
        logic       e_re;
        logic [4:0] e_ra;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic       e_dn;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_dn    = sel ? done_b : done_a;
    assign m_re    = sel ? re_b : re_a;
    assign m_ov    = sel ? ov_b : ov_a;
    assign m_ol    = sel ? ol_b : ol_a;
    assign m_ra    = sel ? ra_b : ra_a;
    assign m_od    = sel ? od_b : od_a;

    initial begin
        for (int i = 0; i < 32; i++) mem_a[i] = 8'(i + 8'h40);
        for (int i = 0; i < 20; i++) mem_b[i] = 8'(i + 8'h40);
    end

    always @(posedge clk) begin
        if (re_a) rd_a <= mem_a[ra_a];
        if (re_b) rd_b <= (ra_b < 5'd20) ? mem_b[ra_b] : 8'hEE;
    end

    mem_stream_reader #(.addresses(32), .width(8)) dut_a (
        .clk(clk), .resetN(resetN), .start(start_a), .startAddress(startAddress),
        .length(length), .busy(busy_a), .done(done_a), .readAddress(ra_a),
        .readEnable(re_a), .readData(rd_a), .outValid(ov_a), .outData(od_a),
        .outLast(ol_a), .outReady(outReady), .state_debug(st_a)
    );

    mem_stream_reader #(.addresses(20), .width(8)) dut_b (
        .clk(clk), .resetN(resetN), .start(start_b), .startAddress(startAddress),
        .length(length), .busy(busy_b), .done(done_b), .readAddress(ra_b),
        .readEnable(re_b), .readData(rd_b), .outValid(ov_b), .outData(od_b),
        .outLast(ol_b), .outReady(outReady), .state_debug(st_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic ready_bit(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 3) == 1;
            2:       return !(cyc >= 3 && cyc <= 9);
            default: return 1'b1;
        endcase
    endfunction

    // Issues one command from the current (pre-edge) cycle and follows it to its done cycle;
    // returns still inside the done cycle so a caller can start the next command there.
    task automatic run_cmd(input int depth, input int saddr, input int len, input int mode,
                           input bit poke);
        int         cyc;
        int         outstanding;
        bit         prev_stall, last_seen, finished, pop_now;
        logic [7:0] prev_od;
        logic [31:0] exp_word, exp_addr;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(5'((saddr + i) % depth));
            exp_q.push_back(8'(((saddr + i) % depth) + 8'h40));
        end
        start = 1'b1;
        startAddress = 5'(saddr);
        length = 6'(len);
        outReady = 1'b1;
        #1 check("cmd_from_idle", 32'(m_busy), 32'd0);
        @(negedge clk);
        cyc = 1; outstanding = 0; prev_stall = 0; last_seen = 0; finished = 0; prev_od = '0;
        while (!finished && cyc < 300) begin
            outReady = ready_bit(mode, cyc);
            start = poke && (cyc == 4);
            if (start) begin
                startAddress = 5'd2;
                length = 6'd3;
            end
            #1;
            pop_now = m_ov && outReady;
            if (last_seen) begin
                check("done_pulse", 32'(m_dn), 32'd1);
                check("done_not_busy", 32'(m_busy), 32'd0);
                check("all_words_seen", 32'(exp_q.size()), 32'd0);
                if (mode == 0) check("done_cycle", 32'(cyc), 32'(len + 3));
                finished = 1;
            end else begin
                check("busy_run", 32'(m_busy), 32'd1);
                check("no_early_done", 32'(m_dn), 32'd0);
                if (cyc < 3) check("first_word_latency", 32'(m_ov), 32'd0);
                if (cyc == 3) check("first_word_cycle3", 32'(m_ov), 32'd1);
                if (m_re) begin
                    check("issue_limit", 32'((outstanding - int'(pop_now)) < 2), 32'd1);
                    exp_addr = (addr_q.size() != 0) ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF;
                    check("read_addr", 32'(m_ra), exp_addr);
                end
                if (prev_stall) check("stall_stable", {23'd0, m_ov, m_od}, {23'd0, 1'b1, prev_od});
                if (pop_now) begin
                    exp_word = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                    check("out_data", 32'(m_od), exp_word);
                    check("out_last", 32'(m_ol), 32'(exp_q.size() == 0));
                    if (m_ol) last_seen = 1;
                end
            end
            outstanding = outstanding + int'(m_re) - int'(pop_now);
            prev_stall = m_ov && !outReady;
            prev_od = m_od;
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("cmd_completed", 32'(finished), 32'd1);
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd4, 6'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 8'h44, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 8'h45, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 8'h48, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 8'h00, 1'b0, 1'b0};

        resetN = 1'b0; start = 1'b0; sel = 1'b0; startAddress = '0; length = '0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_done_a", 32'(done_a), 32'd0);
        check("reset_re_a", 32'(re_a), 32'd0);
        check("reset_ov_a", 32'(ov_a), 32'd0);
        check("reset_ol_a", 32'(ol_a), 32'd0);
        check("reset_ra_a", 32'(ra_a), 32'd0);
        check("reset_od_a", 32'(od_a), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        check("reset_ov_b", 32'(ov_b), 32'd0);
        check("reset_ra_b", 32'(ra_b), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Basic burst on the 32-word instance, cycle by cycle from the start cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = vecs[i].start;
            startAddress = vecs[i].addr;
            length = vecs[i].len;
            outReady = vecs[i].rdy;
            #1;
            check($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(vecs[i].e_busy));
            check($sformatf("tbl%0d_re", i), 32'(re_a), 32'(vecs[i].e_re));
            check($sformatf("tbl%0d_ra", i), 32'(ra_a), 32'(vecs[i].e_ra));
            check($sformatf("tbl%0d_ov", i), 32'(ov_a), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) check($sformatf("tbl%0d_od", i), 32'(od_a), 32'(vecs[i].e_od));
            check($sformatf("tbl%0d_ol", i), 32'(ol_a), 32'(vecs[i].e_ol));
            check($sformatf("tbl%0d_done", i), 32'(done_a), 32'(vecs[i].e_dn));
        end

        @(negedge clk);
        run_cmd(32, 0, 6, 1, 1'b1);
        @(negedge clk);
        run_cmd(32, 9, 5, 2, 1'b0);
        @(negedge clk);
        run_cmd(32, 28, 7, 0, 1'b0);
        run_cmd(32, 3, 4, 1, 1'b0);
        @(negedge clk);
        run_cmd(32, 7, 32, 0, 1'b0);

        // Zero-length command: no reads, done next cycle, never busy.
        @(negedge clk);
        start = 1'b1; startAddress = 5'd3; length = 6'd0; outReady = 1'b1;
        #1 check("zero_busy_c0", 32'(busy_a), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done", 32'(done_a), 32'd1);
        check("zero_busy_c1", 32'(busy_a), 32'd0);
        check("zero_no_read_c1", 32'(re_a), 32'd0);
        @(negedge clk);
        #1;
        check("zero_done_once", 32'(done_a), 32'd0);
        check("zero_no_read_c2", 32'(re_a), 32'd0);

        @(negedge clk);
        sel = 1'b1;
        run_cmd(20, 18, 4, 0, 1'b0);
        run_cmd(20, 5, 20, 1, 1'b0);

        // Reset mid-command: two words taken, a third held under backpressure.
        @(negedge clk);
        sel = 1'b0;
        start = 1'b1; startAddress = 5'd10; length = 6'd8; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        outReady = 1'b0;
        #1;
        check("pre_reset_held_valid", 32'(ov_a), 32'd1);
        check("pre_reset_held_data", 32'(od_a), 32'h4C);
        #2 resetN = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy_a), 32'd0);
        check("mid_reset_done", 32'(done_a), 32'd0);
        check("mid_reset_re", 32'(re_a), 32'd0);
        check("mid_reset_ov", 32'(ov_a), 32'd0);
        check("mid_reset_ol", 32'(ol_a), 32'd0);
        check("mid_reset_ra", 32'(ra_a), 32'd0);
        check("mid_reset_od", 32'(od_a), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        run_cmd(32, 20, 5, 0, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
